// File: rtl/red_pitaya_sys_master.sv
// ---------------------------------------------------------------------------
// red_pitaya_sys_master
//
// Converts one command at a time into a single-cycle read or write strobe on
// the Red Pitaya "sys" bus. It then waits for the responder's ack or error and
// returns a single response to the command side. If the responder stays
// silent for TMO cycles, the module returns an error/timeout response instead.
//
// Handshake rule, used on both sides: a transfer happens at a rising clk_i
// edge where valid and ready are both high. The side asserting valid holds its
// payload stable until that edge.
//
// Parameters
//   TMO          : number of WAIT cycles before a timeout (1..255)
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   rstn_i       : asynchronous active-low reset
//   cmd_valid_i  : command request
//   cmd_ready_o  : command accepted when high with cmd_valid_i (IDLE only)
//   cmd_wr_i     : 1 = write, 0 = read
//   cmd_addr_i   : command address
//   cmd_wdata_i  : command write data
//   rsp_valid_o  : response available (held until rsp_ready_i)
//   rsp_ready_i  : response consumer ready
//   rsp_rdata_o  : read data (0 for writes, errors and timeouts)
//   rsp_err_o    : bus error or timeout
//   rsp_tmo_o    : timeout occurred
//   sys_addr     : bus address, stable from the strobe until the next command
//   sys_wdata    : bus write data, same stability as sys_addr
//   sys_wen      : one-cycle write strobe
//   sys_ren      : one-cycle read strobe
//   sys_rdata    : bus read data
//   sys_err      : bus error indicator
//   sys_ack      : bus acknowledge
//   dbg_state_o  : current FSM state (IDLE=0, STROBE=1, WAIT=2, RESP=3)
// ---------------------------------------------------------------------------
module red_pitaya_sys_master #(
  parameter int unsigned TMO = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // command side
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  // response side
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_tmo_o,
  // system bus
  output logic [31:0] sys_addr,
  output logic [31:0] sys_wdata,
  output logic        sys_wen,
  output logic        sys_ren,
  input  logic [31:0] sys_rdata,
  input  logic        sys_err,
  input  logic        sys_ack,
  // debug
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Last counter value of a WAIT phase; reaching it without ack/err times out.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_e      state_q,     state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        wr_q,        wr_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] wdata_q,     wdata_d;
  logic        wen_q,       wen_d;
  logic        ren_q,       ren_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        rsp_tmo_q,   rsp_tmo_d;

  // Next-state logic. sys_ack/sys_err are only looked at in WAIT, so an ack
  // arriving after a timeout (or after a reset) cannot produce a response.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;

    case (state_q)
      IDLE: begin
        // Ready rises on the first edge after reset and stays up while idle.
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          wr_d        = cmd_wr_i;
          addr_d      = cmd_addr_i;
          wdata_d     = cmd_wdata_i;
          // Strobe is registered here so it is high during the STROBE cycle.
          wen_d       = cmd_wr_i;
          ren_d       = ~cmd_wr_i;
          state_d     = STROBE;
        end
      end

      STROBE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end

      WAIT: begin
        if (sys_err) begin
          // Error wins over a simultaneous ack; data is never passed on.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b0;
          rsp_rdata_d = 32'd0;
          state_d     = RESP;
        end else if (sys_ack) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
          rsp_rdata_d = wr_q ? 32'd0 : sys_rdata;
          state_d     = RESP;
        end else if (cnt_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_rdata_d = 32'd0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      cnt_q       <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign sys_addr    = addr_q;
  assign sys_wdata   = wdata_q;
  assign sys_wen     = wen_q;
  assign sys_ren     = ren_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_red_pitaya_sys_master.sv
// ---------------------------------------------------------------------------
// Testbench for red_pitaya_sys_master (TMO = 4).
// Each transaction record describes the command, how the responder behaves,
// and the expected response. Directed records carry hand-computed
// expectations. Random records get theirs from ref_model().
// ---------------------------------------------------------------------------
module tb_red_pitaya_sys_master;

  localparam int TB_TMO = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_tmo;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic        sys_wen, sys_ren, sys_err, sys_ack;
  logic [1:0]  dbg_state;

  red_pitaya_sys_master #(.TMO(TB_TMO)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_wr_i    (cmd_wr),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .rsp_tmo_o   (rsp_tmo),
    .sys_addr    (sys_addr),
    .sys_wdata   (sys_wdata),
    .sys_wen     (sys_wen),
    .sys_ren     (sys_ren),
    .sys_rdata   (sys_rdata),
    .sys_err     (sys_err),
    .sys_ack     (sys_ack),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];  // {rdata, err, tmo}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction records ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;     // WAIT cycle (1-based) in which responder answers, 0 = never
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    int          hold;    // cycles rsp_ready stays low once the response is up
    logic        stale;   // inject an ack/err while the response is held
    logic [31:0] x_rdata;
    logic        x_err;
    logic        x_tmo;
    int          x_lat;   // acceptance edge to first rsp_valid cycle
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int dly, input logic ack, input logic err,
                              input logic [31:0] rdata, input int hold, input logic stale,
                              input logic [31:0] x_rdata, input logic x_err,
                              input logic x_tmo, input int x_lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.dly = dly; v.ack = ack; v.err = err;
    v.rdata = rdata; v.hold = hold; v.stale = stale; v.x_rdata = x_rdata;
    v.x_err = x_err; v.x_tmo = x_tmo; v.x_lat = x_lat;
    return v;
  endfunction

  // Behavioural reference: a responder answering inside the TB_TMO-cycle
  // window decides the outcome; anything else is a timeout.
  function automatic void ref_model(inout vec_t v);
    if (v.dly >= 1 && v.dly <= TB_TMO && (v.ack || v.err)) begin
      v.x_err   = v.err;
      v.x_tmo   = 1'b0;
      v.x_rdata = (v.err || v.wr) ? 32'd0 : v.rdata;
      v.x_lat   = 2 + v.dly;
    end else begin
      v.x_err   = 1'b1;
      v.x_tmo   = 1'b1;
      v.x_rdata = 32'd0;
      v.x_lat   = 2 + TB_TMO;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input vec_t v);
    int lat, nw, nr, waited;
    logic [33:0] e;
    exp_q.push_back({v.x_rdata, v.x_err, v.x_tmo});
    cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_valid = 1'b1;
    rsp_ready = (v.hold == 0);
    waited = 0;
    while (!cmd_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      e = exp_q.pop_front();
      return;
    end
    @(posedge clk);  // acceptance edge E
    lat = 0; nw = 0; nr = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0;
        chk("strobe_addr", sys_addr, v.addr);
        chk("strobe_wdata", sys_wdata, v.wdata);
      end
      nw += int'(sys_wen);
      nr += int'(sys_ren);
      if (v.dly != 0 && c == v.dly + 1) begin
        sys_ack = v.ack; sys_err = v.err; sys_rdata = v.rdata;
      end else begin
        sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = $urandom;
      end
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(v.x_lat));
    chk("strobe_count", 32'(v.wr ? nw : nr), 1);
    chk("wrong_strobe_count", 32'(v.wr ? nr : nw), 0);
    e = exp_q.pop_front();
    chk("rsp_rdata", rsp_rdata, e[33:2]);
    chk("rsp_err", 32'(rsp_err), 32'(e[1]));
    chk("rsp_tmo", 32'(rsp_tmo), 32'(e[0]));
    for (int h = 1; h <= v.hold; h++) begin
      @(negedge clk);
      sys_ack = 1'b0; sys_err = 1'b0;
      if (v.stale && h == 2) begin
        sys_ack = 1'b1; sys_err = 1'b1; sys_rdata = 32'hBAD0BAD0;
      end
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_rdata", rsp_rdata, e[33:2]);
      chk("hold_err", 32'(rsp_err), 32'(e[1]));
      chk("hold_tmo", 32'(rsp_tmo), 32'(e[0]));
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
      if (h == v.hold) rsp_ready = 1'b1;
    end
    @(negedge clk);  // one cycle after the response handshake
    sys_ack = 1'b0; sys_err = 1'b0; rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_cmd_ready", 32'(cmd_ready), 1);
    chk("addr_held", sys_addr, v.addr);
    chk("wdata_held", sys_wdata, v.wdata);
    chk("post_wen", 32'(sys_wen), 0);
    chk("post_ren", 32'(sys_ren), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_rsp_tmo"}, 32'(rsp_tmo), 0);
    chk({tag, "_sys_wen"}, 32'(sys_wen), 0);
    chk({tag, "_sys_ren"}, 32'(sys_ren), 0);
    chk({tag, "_sys_addr"}, sys_addr, 0);
    chk({tag, "_sys_wdata"}, sys_wdata, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  vec_t vecs[9];

  initial begin
    //          wr    addr          wdata         dly ack   err   rdata         hold stale x_rdata       x_err x_tmo lat
    vecs[0] = mk(1'b0, 32'h00000004, 32'h00000000, 1, 1'b1, 1'b0, 32'h89ABCDE0, 0, 1'b0, 32'h89ABCDE0, 1'b0, 1'b0, 3);
    vecs[1] = mk(1'b1, 32'h0000000C, 32'h00000001, 1, 1'b1, 1'b0, 32'h77777777, 0, 1'b0, 32'h00000000, 1'b0, 1'b0, 3);
    vecs[2] = mk(1'b0, 32'h00000100, 32'h00000000, 0, 1'b0, 1'b0, 32'h00000000, 3, 1'b1, 32'h00000000, 1'b1, 1'b1, 6);
    vecs[3] = mk(1'b0, 32'h00000104, 32'h00000000, 1, 1'b1, 1'b0, 32'h55AA55AA, 0, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 3);
    vecs[4] = mk(1'b0, 32'h00000008, 32'h00000000, 1, 1'b1, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 32'h00000000, 1'b1, 1'b0, 3);
    vecs[5] = mk(1'b0, 32'h00000010, 32'h00000000, 4, 1'b1, 1'b0, 32'h12345678, 0, 1'b0, 32'h12345678, 1'b0, 1'b0, 6);
    vecs[6] = mk(1'b1, 32'h00000020, 32'h0000ABCD, 2, 1'b0, 1'b1, 32'h11111111, 1, 1'b0, 32'h00000000, 1'b1, 1'b0, 4);
    vecs[7] = mk(1'b0, 32'h00000030, 32'h00000000, 1, 1'b1, 1'b0, 32'hCAFEF00D, 10, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 3);
    vecs[8] = mk(1'b0, 32'h00000040, 32'h00000000, 5, 1'b1, 1'b0, 32'h99999999, 0, 1'b0, 32'h00000000, 1'b1, 1'b1, 6);

    rstn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; sys_rdata = '0; sys_err = 1'b0; sys_ack = 1'b0;

    // reset state, then ready must rise at the first edge after release
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    #1;
    chk("release_cmd_ready_before_edge", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("release_cmd_ready_first_edge", 32'(cmd_ready), 1);

    // directed table
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // reset while waiting for the responder
    cmd_wr = 1'b0; cmd_addr = 32'h00000200; cmd_wdata = 32'h0000AAAA; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    chk("rst_seq_strobe", 32'(sys_ren), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    sys_ack = 1'b1; sys_rdata = 32'hDEADBEEF;
    @(negedge clk);
    sys_ack = 1'b0;
    chk("after_reset_cmd_ready", 32'(cmd_ready), 1);
    chk("after_reset_no_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("after_reset_no_rsp_late", 32'(rsp_valid), 0);
    chk("after_reset_no_strobe", 32'(sys_ren), 0);
    run_txn(mk(1'b0, 32'h00000204, 32'h0, 2, 1'b1, 1'b0, 32'h0BADF00D, 0, 1'b0,
               32'h0BADF00D, 1'b0, 1'b0, 4));

    // randomized transactions checked against the reference model
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int k;
      k = $urandom_range(0, 3);
      v = mk($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 6),
             (k == 1 || k == 3), (k == 2 || k == 3), $urandom, $urandom_range(0, 2),
             $urandom_range(0, 3) == 0, 32'd0, 1'b0, 1'b0, 0);
      ref_model(v);
      run_txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
